// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module   : window_3x3_gen
//  Purpose  : Streaming 3x3 window generator. Takes a raster-order pixel
//             stream, keeps the two previous lines in line buffers and emits
//             every fully-interior 3x3 neighbourhood as nine parallel pixels.
//  Ports    : clk, rst (async, active-low)
//             in_valid / in_sof / in_pixel   - input stream, no backpressure
//             win_valid, pixel_out0..8       - registered window, row-major
//                                              (0-2 top, 3-5 mid, 6-8 bottom)
//             frame_done                     - pulses with the last window
//             busy                           - frame in progress
//  Revision : 1.0  initial release
// ============================================================================
module window_3x3_gen #(
  parameter int DW    = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_pixel,
  output logic          win_valid,
  output logic [DW-1:0] pixel_out0,
  output logic [DW-1:0] pixel_out1,
  output logic [DW-1:0] pixel_out2,
  output logic [DW-1:0] pixel_out3,
  output logic [DW-1:0] pixel_out4,
  output logic [DW-1:0] pixel_out5,
  output logic [DW-1:0] pixel_out6,
  output logic [DW-1:0] pixel_out7,
  output logic [DW-1:0] pixel_out8,
  output logic          frame_done,
  output logic          busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  logic          start, accept, emit, last_px;

  logic [DW-1:0] lb1 [IMG_W];   // row r-1
  logic [DW-1:0] lb2 [IMG_W];   // row r-2
  // Two previous columns of each window row; index 1 is the newer column.
  // The third (newest) column comes straight from the buffers / input.
  logic [DW-1:0] tap [3][2];
  logic [DW-1:0] up1, up2;
  logic [DW-1:0] win     [9];
  logic [DW-1:0] win_nxt [9];

  // Position of the pixel being accepted. A start-of-frame pixel is always
  // (0,0) regardless of where the counters stand, which covers abort too.
  always_comb begin
    start   = in_valid & in_sof;
    accept  = in_valid & (in_sof | (state != IDLE));
    pos_col = start ? '0 : col;
    pos_row = start ? '0 : row;
    last_px = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    emit    = accept && !start && (state == RUN) &&
              (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    up1     = lb1[pos_col];
    up2     = lb2[pos_col];
  end

  always_comb begin
    win_nxt[0] = tap[0][0];
    win_nxt[1] = tap[0][1];
    win_nxt[2] = up2;
    win_nxt[3] = tap[1][0];
    win_nxt[4] = tap[1][1];
    win_nxt[5] = up1;
    win_nxt[6] = tap[2][0];
    win_nxt[7] = tap[2][1];
    win_nxt[8] = in_pixel;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        if (start)
          state_nxt = FILL;
        else if (accept && (pos_col == COL_LAST) && (pos_row == RW'(1)))
          state_nxt = RUN;
      end
      RUN: begin
        if (start)
          state_nxt = FILL;
        else if (accept && last_px)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      state      <= state_nxt;
      win_valid  <= emit;
      frame_done <= emit & last_px;
      if (accept) begin
        if (pos_col == COL_LAST) begin
          col <= '0;
          row <= last_px ? '0 : pos_row + RW'(1);
        end else begin
          col <= pos_col + CW'(1);
          row <= pos_row;
        end
      end
      if (emit) begin
        for (int i = 0; i < 9; i++) win[i] <= win_nxt[i];
      end
    end
  end

  // Storage is not reset: every location is rewritten during FILL before
  // any window that depends on it can be emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[pos_col] <= up1;
      lb1[pos_col] <= in_pixel;
      tap[0][0]    <= tap[0][1];
      tap[0][1]    <= up2;
      tap[1][0]    <= tap[1][1];
      tap[1][1]    <= up1;
      tap[2][0]    <= tap[2][1];
      tap[2][1]    <= in_pixel;
    end
  end

  assign busy       = (state != IDLE);
  assign pixel_out0 = win[0];
  assign pixel_out1 = win[1];
  assign pixel_out2 = win[2];
  assign pixel_out3 = win[3];
  assign pixel_out4 = win[4];
  assign pixel_out5 = win[5];
  assign pixel_out6 = win[6];
  assign pixel_out7 = win[7];
  assign pixel_out8 = win[8];

endmodule
`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_3x3_gen
//  Purpose  : Directed self-checking bench for window_3x3_gen. Instance a is
//             4x4, instance b is 5x3; both share the input stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_3x3_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pixel;

  logic       va, fda, busya;
  logic       vb, fdb, busyb;
  logic [7:0] pa [9];
  logic [7:0] pb [9];

  int checks   = 0;
  int failures = 0;

  logic [71:0] last_win [2];
  logic [71:0] first_g;
  int          nwin_g;

  always #5 clk = ~clk;

  window_3x3_gen #(.DW(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .win_valid(va),
    .pixel_out0(pa[0]), .pixel_out1(pa[1]), .pixel_out2(pa[2]),
    .pixel_out3(pa[3]), .pixel_out4(pa[4]), .pixel_out5(pa[5]),
    .pixel_out6(pa[6]), .pixel_out7(pa[7]), .pixel_out8(pa[8]),
    .frame_done(fda), .busy(busya)
  );

  window_3x3_gen #(.DW(8), .IMG_W(5), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .win_valid(vb),
    .pixel_out0(pb[0]), .pixel_out1(pb[1]), .pixel_out2(pb[2]),
    .pixel_out3(pb[3]), .pixel_out4(pb[4]), .pixel_out5(pb[5]),
    .pixel_out6(pb[6]), .pixel_out7(pb[7]), .pixel_out8(pb[8]),
    .frame_done(fdb), .busy(busyb)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a, b, c, d, e, f, g, h, i);
    logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8, i8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0]; e8 = e[7:0];
    f8 = f[7:0]; g8 = g[7:0]; h8 = h[7:0]; i8 = i[7:0];
    return {a8, b8, c8, d8, e8, f8, g8, h8, i8};
  endfunction

  // Window ending at (r,c) of a frame whose pixel at index k is base+k.
  function automatic logic [71:0] model(input int base, input int r, input int c, input int w);
    logic [71:0] res;
    int          v;
    res = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v   = base + (r - 2 + dr) * w + (c - 2 + dc);
        res = {res[63:0], v[7:0]};
      end
    return res;
  endfunction

  function automatic logic [71:0] get_win(input bit sel);
    if (sel) return {pb[0], pb[1], pb[2], pb[3], pb[4], pb[5], pb[6], pb[7], pb[8]};
    return {pa[0], pa[1], pa[2], pa[3], pa[4], pa[5], pa[6], pa[7], pa[8]};
  endfunction

  task automatic check_outs(input bit sel, input bit ev, input logic [71:0] ew,
                            input bit efd, input bit ebusy, input string tag);
    check($sformatf("%s_valid", tag), sel ? vb : va, ev);
    check($sformatf("%s_fdone", tag), sel ? fdb : fda, efd);
    check($sformatf("%s_busy", tag), sel ? busyb : busya, ebusy);
    if (ev) begin
      check($sformatf("%s_win", tag), get_win(sel), ew);
      last_win[sel] = ew;
    end else begin
      check($sformatf("%s_hold", tag), get_win(sel), last_win[sel]);
    end
  endtask

  task automatic send(input bit sel, input int pix, input bit sof, input bit ev,
                      input logic [71:0] ew, input bit efd, input bit ebusy, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix[7:0];
    @(posedge clk);
    #1;
    check_outs(sel, ev, ew, efd, ebusy, tag);
  endtask

  // Idle cycles; in_sof is raised without in_valid, which must be ignored.
  task automatic bubble(input bit sel, input int n, input bit ebusy, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b1;
      @(posedge clk);
      #1;
      check_outs(sel, 1'b0, '0, 1'b0, ebusy, tag);
    end
    @(negedge clk);
    in_sof = 1'b0;
  endtask

  task automatic run_frame(input bit sel, input int base, input int npix,
                           input int bub1, input int bub2, input string tag);
    int w, h, r, c;
    bit ev, efd;
    w      = sel ? 5 : 4;
    h      = sel ? 3 : 4;
    nwin_g = 0;
    first_g = '0;
    for (int i = 0; i < npix; i++) begin
      r   = i / w;
      c   = i % w;
      ev  = (r >= 2) && (c >= 2);
      efd = (i == w * h - 1);
      send(sel, base + i, i == 0, ev, ev ? model(base, r, c, w) : 72'd0, efd, !efd,
           $sformatf("%s_p%0d", tag, i));
      if (ev) begin
        if (nwin_g == 0) first_g = get_win(sel);
        nwin_g++;
      end
      if (i == bub1 || i == bub2) bubble(sel, 3, 1'b1, $sformatf("%s_bub%0d", tag, i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #2 rst = 1'b0;
    #1;
    last_win[0] = '0;
    last_win[1] = '0;
    check_outs(1'b0, 1'b0, '0, 1'b0, 1'b0, $sformatf("%s_a", tag));
    check_outs(1'b1, 1'b0, '0, 1'b0, 1'b0, $sformatf("%s_b", tag));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = 8'd0;
    last_win[0] = '0;
    last_win[1] = '0;
    repeat (2) @(posedge clk);
    do_reset("t0_rst");

    // Test 1: basic frame 1..16
    run_frame(1'b0, 1, 16, -1, -1, "t1");
    check("t1_first", first_g, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check("t1_last", get_win(1'b0), pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    check("t1_count", nwin_g, 4);

    // Test 2: bubbles between 10/11 and 14/15
    run_frame(1'b0, 1, 16, 9, 13, "t2");
    check("t2_first", first_g, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check("t2_count", nwin_g, 4);

    // Test 3: reset after pixel 9, then frame 101..116
    run_frame(1'b0, 1, 9, -1, -1, "t3a");
    do_reset("t3_rst");
    run_frame(1'b0, 101, 16, -1, -1, "t3b");
    check("t3_first", first_g, pack9(101, 102, 103, 105, 106, 107, 109, 110, 111));
    check("t3_count", nwin_g, 4);

    // Test 4: sof on pixel 7 aborts the frame
    run_frame(1'b0, 1, 6, -1, -1, "t4a");
    run_frame(1'b0, 50, 16, -1, -1, "t4b");
    check("t4_first", first_g, pack9(50, 51, 52, 54, 55, 56, 58, 59, 60));

    // Test 5: pixels without sof in IDLE are dropped
    for (int k = 0; k < 3; k++)
      send(1'b0, 9, 1'b0, 1'b0, '0, 1'b0, 1'b0, $sformatf("t5_idle%0d", k));
    run_frame(1'b0, 1, 16, -1, -1, "t5");
    check("t5_first", first_g, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check("t5_last", get_win(1'b0), pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));

    // Test 6: back-to-back 5x3 frames on instance b
    do_reset("t6_rst");
    run_frame(1'b1, 1, 15, -1, -1, "t6a");
    check("t6a_first", first_g, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    check("t6a_count", nwin_g, 3);
    run_frame(1'b1, 101, 15, -1, -1, "t6b");
    check("t6b_count", nwin_g, 3);
    check("t6b_last", get_win(1'b1), pack9(103, 104, 105, 108, 109, 110, 113, 114, 115));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
